// File: rtl/serial_receiver.sv
// Serial frame receiver: start bit, 8 data bits LSB-first, stop bit, sampled on i_en.
// Good bytes land in a small FWFT FIFO drained over a valid/ready handshake.
module serial_receiver #(
  parameter logic START_LVL = 1'b1,
  parameter int   DEPTH     = 4,
  parameter int   CW        = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_s_data,
  input  logic          i_ready,
  output logic [7:0]    o_data,
  output logic          o_valid,
  output logic [CW-1:0] o_count,
  output logic          o_busy,
  output logic          o_frame_err,
  output logic          o_overflow
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            frame_err_q, frame_err_d;
  logic            overflow_q, overflow_d;
  logic            push, pop, full;

  assign o_valid     = (count_q != '0);
  assign o_data      = o_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign o_count     = count_q;
  assign o_busy      = (state_q != IDLE);
  assign o_frame_err = frame_err_q;
  assign o_overflow  = overflow_q;

  assign full = (count_q == CW'(DEPTH));
  assign pop  = o_valid && i_ready;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    overflow_d  = 1'b0;
    if (i_en) begin
      case (state_q)
        IDLE: if (i_s_data == START_LVL) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
        DATA: begin
          shift_d   = {i_s_data, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
          if (i_s_data != START_LVL) begin
            if (!full || pop) push = 1'b1;
            else              overflow_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end
endmodule

// File: doc/serial_receiver.md
Name: serial_receiver

Overview:
- Downstream partner of the serial transmitter. Samples the 1-bit serial stream one bit per enabled cycle and recovers 10-bit frames: start bit, 8 data bits LSB-first, stop bit.
- Checks framing and pushes good bytes into a small first-word-fall-through FIFO.
- Presents bytes to the consumer over a valid/ready handshake.

Parameters:
- START_LVL, 1'b1, level of the start bit. Idle line level and stop-bit level are both ~START_LVL.
- DEPTH, 4, output FIFO depth in bytes. Must be a power of 2, minimum 2.
- CW, 3, width of o_count. Must equal log2(DEPTH)+1.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  synchronous, active-high reset
- i_en  input  1  bit strobe; i_s_data is sampled only on cycles where i_en=1
- i_s_data  input  1  serial data in
- i_ready  input  1  consumer accepts o_data this cycle
- o_data  output  8  head-of-FIFO byte; valid only while o_valid=1
- o_valid  output  1  FIFO not empty
- o_count  output  CW  bytes currently held, 0..DEPTH
- o_busy  output  1  FSM not in IDLE
- o_frame_err  output  1  one-cycle pulse: bad stop bit
- o_overflow  output  1  one-cycle pulse: good byte dropped because FIFO full

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - FSM to IDLE; shift register, bit counter, FIFO pointers and count cleared.
  - o_data=0, o_valid=0, o_count=0, o_busy=0, o_frame_err=0, o_overflow=0.
  - Reset mid-frame discards the partial frame and all FIFO contents. Reset wins over every other event.
- FSM advances only on cycles with i_en=1. With i_en=0 the FSM, shift register and bit counter hold. FIFO pops still occur.
- FSM states:
  - IDLE: sample == START_LVL → DATA with bit_cnt=0. Otherwise stay in IDLE.
  - DATA: shift the sample in LSB-first, so data bit 0 lands in shift[0]. bit_cnt increments each sample. After the 8th sample (bit_cnt==7) → STOP.
  - STOP, sample == ~START_LVL: the byte is good. If the FIFO is not full, or a pop happens this same cycle, push the byte; otherwise drop it and pulse o_overflow. Go to IDLE.
  - STOP, sample == START_LVL: pulse o_frame_err, drop the byte, go to IDLE. No resynchronisation attempt; the next START_LVL sample in IDLE starts a new frame.
- o_busy=1 in DATA and STOP.
- Latency: a pushed byte appears on o_data with o_valid=1 on the cycle after the stop-bit sample edge. This holds when the FIFO was empty, because the FIFO is FWFT.
- Handshake:
  - Pop occurs when o_valid && i_ready.
  - o_data and o_valid stay stable while o_valid=1 && i_ready=0.
  - i_ready with o_valid=0 has no effect.
- Simultaneous push and pop:
  - When empty: push only; the pop is ignored because o_valid=0.
  - When full: both occur, o_count stays DEPTH, no overflow.
  - Otherwise: o_count unchanged.
- Pointers wrap modulo DEPTH.
- o_count = pushes − pops. It never exceeds DEPTH and never goes below 0.
- o_frame_err and o_overflow are registered and high for exactly one cycle per event. They are mutually exclusive.
- Back-to-back frames: the start bit of the next frame may be sampled on the enabled cycle immediately after the stop bit.

Test Plan:
- Reset, then i_en=1 continuously with bits 1,0xA5 LSB-first (1,0,1,0,0,1,0,1),0 → o_valid rises one cycle after the stop edge, o_data=0xA5, o_count=1, no error pulses.
- Same frame with i_en toggling 1,0,1,0… → o_data=0xA5. Recovery takes exactly twice as many cycles. FSM holds on i_en=0 cycles.
- Frame 0x3C with stop bit =1 → o_frame_err high exactly 1 cycle, o_count stays 0. A following valid 0x3C frame is then received correctly.
- i_ready=0; send 5 good frames 0x01..0x05 with DEPTH=4 → o_count=4, o_overflow pulses once on the 5th stop bit. Draining yields 0x01,0x02,0x03,0x04.
- FIFO full; i_ready=1 on the stop-bit cycle of frame 0x77 → pop and push both occur, no overflow, o_count=4, 0x77 ends last in the drain order.
- i_rst asserted after 4 data bits of a frame, with 2 bytes queued → next cycle o_valid=0, o_count=0, o_busy=0. A following frame 0xC3 is received cleanly.
